demux16_capture: RTL and testbench
==================================

// Module: demux16_capture
// PURPOSE
// - Serial-to-parallel receiver and the inverse of the 16:1 select mux. A 1-bit stream indexed by an internal
//   4-bit select counter is steered into 16 output bit positions.
// - After start, consumes 16 valid bits and writes bit k to position k, LSB first.
// - Then presents the assembled 16-bit word with a 1-cycle dout_valid pulse.
// - Sits downstream of any block that scans a 16-bit word out serially with a 4-bit select.
// PARAMETERS
// - SEL_W      4        select/index width; word width OUT_W = 1<<SEL_W (16)
// - MSB_FIRST  0        0: first accepted bit -> dout[0]; 1: first accepted bit -> dout[OUT_W-1]
// PORTS
// - clk         in   1      single clock, rising edge
// - rst_n       in   1      synchronous, active-low reset
// - start       in   1      begin a capture; honoured only in IDLE
// - abort       in   1      drop the current capture and return to IDLE; no dout_valid
// - din         in   1      serial data bit
// - din_valid   in   1      din is accepted this cycle (CAPTURE only)
// - busy        out  1      1 while in CAPTURE
// - sel         out  SEL_W  index the next accepted bit will be written to
// - dout        out  OUT_W  last completed word; held until the next completion
// - dout_valid  out  1      1-cycle pulse when dout updates
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge) overrides all other inputs. At reset: state=IDLE, sel=0, shadow=0, dout=0,
//   dout_valid=0, busy=0. A reset mid-capture discards partial data.
// - FSM states: IDLE, CAPTURE.
//   - IDLE -> CAPTURE when start=1.
//   - CAPTURE -> IDLE on the 16th accepted bit, or on abort.
// - Entering CAPTURE sets sel=0. A din_valid in the same cycle as start is ignored; accepted bits begin the
//   following cycle.
// - In CAPTURE with din_valid=1:
//   - shadow[pos(sel)] <= din, where pos(sel) = MSB_FIRST ? OUT_W-1-sel : sel.
//   - sel <= sel+1.
//   - din_valid=0 stalls: no write and no increment. Gaps of any length are allowed.
// - Completion: when sel==OUT_W-1 and din_valid=1:
//   - dout <= shadow with the final bit merged in.
//   - dout_valid=1 in the following cycle, for exactly one cycle.
//   - state returns to IDLE and sel wraps to 0.
// - Latency: with no gaps, start at cycle 0, bits accepted at cycles 1..16, dout and dout_valid visible
//   at cycle 17.
// - Priority when events coincide: rst_n > abort > bit accept.
//   - abort in the same cycle as the 16th bit: the word is dropped and dout_valid stays 0.
//   - abort in IDLE has no effect.
// - start while in CAPTURE is ignored and does not restart sel. start in the dout_valid cycle (already IDLE)
//   is honoured.
// - din_valid in IDLE is ignored. dout is unchanged on abort.
// - busy is registered and equals (state==CAPTURE).
// STRUCTURE
// - Shared package demux_pkg: SEL_W default, OUT_W derivation, state encoding constants
//   (ST_IDLE=1'b0, ST_CAPTURE=1'b1).
// - Sub-module demux1to4: combinational 1:4 one-hot decoder with enable (en, s[1:0] -> y[3:0]).
// - Write-enable tree:
//   - one demux1to4 on sel[3:2], gated by (CAPTURE & din_valid & ~abort);
//   - four demux1to4 on sel[1:0], each enabled by one first-stage output;
//   - result: 16 one-hot write enables for the shadow register.
// - Top-level: FSM, sel counter, shadow and dout registers, dout_valid flop.
// TESTING
// 1. Reset, start at cycle 0, stream 16'hA5C3 LSB-first with no gaps
//    -> dout=16'hA5C3 and dout_valid=1 at cycle 17 only; busy=1 for cycles 1..16.
// 2. Same word with din_valid=0 on every other cycle
//    -> dout=16'hA5C3 after 31 cycles; sel holds during gaps.
// 3. MSB_FIRST=1 instance, stream bits 1,0,0,0 then 12 zeros -> dout=16'h8000.
// 4. abort after 7 bits of 16'hFFFF; previous dout=16'hA5C3
//    -> no dout_valid, dout stays 16'hA5C3, busy=0, sel=0.
//    A new start then captures 16'h0F0F correctly.
// 5. rst_n=0 after 10 bits -> all outputs 0 on the next edge. start pulsed mid-capture in a separate run
//    -> ignored, and the word completes at cycle 17.
// 6. Coincident events:
//    - abort with the 16th bit -> no dout_valid;
//    - start together with the first din_valid -> that bit is not captured;
//    - din_valid in IDLE -> dout unchanged.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 16-bit serial capture block: default select width,
// word-width derivation and the capture FSM state encoding.
package demux_pkg;

    localparam int SEL_W_DEF = 4;

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_CAPTURE = 1'b1;

    function automatic int out_width(input int sel_w);
        return 1 << sel_w;
    endfunction

    localparam int OUT_W_DEF = out_width(SEL_W_DEF);

endpackage

// File: rtl/demux1to4.sv
// Combinational 1:4 one-hot decoder with enable; building block of the
// shadow-register write-enable tree.
module demux1to4 (
    input  logic       en,
    input  logic [1:0] s,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y[s] = 1'b1;
        end
    end

endmodule

// File: rtl/demux16_capture.sv
// Serial-to-parallel capture: steers an accepted 1-bit stream into a shadow
// word indexed by a select counter, then publishes the word with a 1-cycle pulse.
module demux16_capture
    import demux_pkg::*;
#(
    parameter int SEL_W     = SEL_W_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      din,
    input  logic                      din_valid,
    output logic                      busy,
    output logic [SEL_W-1:0]          sel,
    output logic [(1 << SEL_W)-1:0]   dout,
    output logic                      dout_valid
);

    // state | meaning
    // IDLE    | waiting for start; dout holds the last completed word
    // CAPTURE | accepting din on din_valid into shadow[pos(sel)]

    localparam int OUT_W = 1 << SEL_W;

    logic             state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [OUT_W-1:0] shadow_q, shadow_d;
    logic [OUT_W-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             busy_q;

    logic             accept;
    logic [SEL_W-1:0] pos;
    logic [OUT_W-1:0] we;

    assign accept = (state_q == ST_CAPTURE) && din_valid && !abort;
    // OUT_W-1-sel is the bitwise complement of sel for a power-of-two width.
    assign pos    = MSB_FIRST ? ~sel_q : sel_q;

    generate
        if (SEL_W == 4) begin : g_tree
            logic [3:0] grp_en;

            demux1to4 u_grp (
                .en (accept),
                .s  (pos[3:2]),
                .y  (grp_en)
            );

            for (genvar g = 0; g < 4; g++) begin : g_leaf
                demux1to4 u_leaf (
                    .en (grp_en[g]),
                    .s  (pos[1:0]),
                    .y  (we[g*4 +: 4])
                );
            end
        end else begin : g_flat
            assign we = accept ? (OUT_W'(1) << pos) : '0;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;

        for (int i = 0; i < OUT_W; i++) begin
            if (we[i]) begin
                shadow_d[i] = din;
            end
        end

        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_CAPTURE;
                sel_d   = '0;
            end
        end else begin
            if (abort) begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end else if (din_valid) begin
                sel_d = sel_q + 1'b1;
                if (sel_q == '1) begin
                    state_d      = ST_IDLE;
                    dout_d       = shadow_d;
                    dout_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= (state_d == ST_CAPTURE);
        end
    end

    assign busy       = busy_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_demux16_capture.sv
// Scoreboard bench for demux16_capture: LSB-first and MSB-first instances,
// directed captures, stalls, aborts, resets and coincident events.
module tb_demux16_capture;

    logic        clk;
    logic        rst_n;

    logic        start_a, abort_a, din_a, dv_a;
    logic        busy_a, dvo_a;
    logic [3:0]  sel_a;
    logic [15:0] dout_a;

    logic        start_b, abort_b, din_b, dv_b;
    logic        busy_b, dvo_b;
    logic [3:0]  sel_b;
    logic [15:0] dout_b;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q_a[$];
    logic [15:0] exp_q_b[$];

    demux16_capture #(.SEL_W(4), .MSB_FIRST(1'b0)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .abort      (abort_a),
        .din        (din_a),
        .din_valid  (dv_a),
        .busy       (busy_a),
        .sel        (sel_a),
        .dout       (dout_a),
        .dout_valid (dvo_a)
    );

    demux16_capture #(.SEL_W(4), .MSB_FIRST(1'b1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .abort      (abort_b),
        .din        (din_b),
        .din_valid  (dv_b),
        .busy       (busy_b),
        .sel        (sel_b),
        .dout       (dout_b),
        .dout_valid (dvo_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every dout_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && dvo_a) begin
            checks++;
            if (exp_q_a.size() == 0) begin
                failures++;
                $display("FAIL mon_a unexpected dout_valid actual=%0h expected=none", dout_a);
            end else begin
                logic [15:0] e;
                e = exp_q_a.pop_front();
                if (dout_a !== e) begin
                    failures++;
                    $display("FAIL mon_a word actual=%0h expected=%0h", dout_a, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dvo_b) begin
            checks++;
            if (exp_q_b.size() == 0) begin
                failures++;
                $display("FAIL mon_b unexpected dout_valid actual=%0h expected=none", dout_b);
            end else begin
                logic [15:0] e;
                e = exp_q_b.pop_front();
                if (dout_b !== e) begin
                    failures++;
                    $display("FAIL mon_b word actual=%0h expected=%0h", dout_b, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic bit_a(input logic b);
        din_a = b;
        dv_a  = 1'b1;
        step();
        dv_a  = 1'b0;
    endtask

    task automatic bit_b(input logic b);
        din_b = b;
        dv_b  = 1'b1;
        step();
        dv_b  = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        rst_n   = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; din_a = 1'b0; dv_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; din_b = 1'b0; dv_b = 1'b0;
        step();
        step();
        chk("reset_dout", {16'h0, dout_a}, 32'h0);
        chk("reset_sel", {28'h0, sel_a}, 32'h0);
        chk("reset_busy", {31'h0, busy_a}, 32'h0);
        chk("reset_dvo", {31'h0, dvo_a}, 32'h0);
        rst_n = 1'b1;
        step();

        // 1: gapless LSB-first capture, latency 17
        w = 16'hA5C3;
        exp_q_a.push_back(w);
        chk("t1_busy_c0", {31'h0, busy_a}, 32'h0);
        pulse_start_a();
        for (int i = 0; i < 16; i++) begin
            chk("t1_busy", {31'h0, busy_a}, 32'h1);
            chk("t1_dvo_early", {31'h0, dvo_a}, 32'h0);
            chk("t1_sel", {28'h0, sel_a}, i);
            bit_a(w[i]);
        end
        chk("t1_dvo_c17", {31'h0, dvo_a}, 32'h1);
        chk("t1_dout_c17", {16'h0, dout_a}, 32'hA5C3);
        chk("t1_busy_c17", {31'h0, busy_a}, 32'h0);
        chk("t1_sel_wrap", {28'h0, sel_a}, 32'h0);
        step();
        chk("t1_dvo_once", {31'h0, dvo_a}, 32'h0);

        // 2: same word with a stall between every bit
        exp_q_a.push_back(w);
        pulse_start_a();
        for (int i = 0; i < 16; i++) begin
            bit_a(w[i]);
            if (i < 15) begin
                step();
                chk("t2_sel_hold", {28'h0, sel_a}, i + 1);
            end
        end
        chk("t2_dvo", {31'h0, dvo_a}, 32'h1);
        chk("t2_dout", {16'h0, dout_a}, 32'hA5C3);

        // 3: MSB-first instance, first accepted bit lands in dout[15]
        exp_q_b.push_back(16'h8000);
        w = 16'h0001;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bit_b(w[i]);
        end
        chk("t3_dvo", {31'h0, dvo_b}, 32'h1);
        chk("t3_dout", {16'h0, dout_b}, 32'h8000);

        // 4: abort after 7 bits of all-ones keeps previous word
        pulse_start_a();
        for (int i = 0; i < 7; i++) bit_a(1'b1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t4_busy", {31'h0, busy_a}, 32'h0);
        chk("t4_sel", {28'h0, sel_a}, 32'h0);
        chk("t4_dout", {16'h0, dout_a}, 32'hA5C3);
        chk("t4_dvo", {31'h0, dvo_a}, 32'h0);
        w = 16'h0F0F;
        exp_q_a.push_back(w);
        pulse_start_a();
        for (int i = 0; i < 16; i++) bit_a(w[i]);
        chk("t4_dout_new", {16'h0, dout_a}, 32'h0F0F);

        // 5: reset mid-capture, then start pulsed mid-capture is ignored
        pulse_start_a();
        for (int i = 0; i < 10; i++) bit_a(1'b1);
        rst_n = 1'b0;
        step();
        chk("t5_rst_dout", {16'h0, dout_a}, 32'h0);
        chk("t5_rst_sel", {28'h0, sel_a}, 32'h0);
        chk("t5_rst_busy", {31'h0, busy_a}, 32'h0);
        chk("t5_rst_dvo", {31'h0, dvo_a}, 32'h0);
        rst_n = 1'b1;
        step();
        w = 16'h3C5A;
        exp_q_a.push_back(w);
        pulse_start_a();
        for (int i = 0; i < 16; i++) begin
            if (i == 5) start_a = 1'b1;
            bit_a(w[i]);
            start_a = 1'b0;
            if (i == 5) chk("t5_sel_no_restart", {28'h0, sel_a}, 32'h6);
        end
        chk("t5_dvo_c17", {31'h0, dvo_a}, 32'h1);
        chk("t5_dout", {16'h0, dout_a}, 32'h3C5A);

        // 6a: abort coincident with the 16th bit drops the word
        pulse_start_a();
        for (int i = 0; i < 15; i++) bit_a(1'b1);
        abort_a = 1'b1;
        bit_a(1'b1);
        abort_a = 1'b0;
        chk("t6a_dvo", {31'h0, dvo_a}, 32'h0);
        chk("t6a_busy", {31'h0, busy_a}, 32'h0);
        chk("t6a_sel", {28'h0, sel_a}, 32'h0);
        chk("t6a_dout", {16'h0, dout_a}, 32'h3C5A);
        step();
        chk("t6a_dvo_late", {31'h0, dvo_a}, 32'h0);

        // 6b: bit presented with start is not captured
        w = 16'h1234;
        exp_q_a.push_back(w);
        start_a = 1'b1;
        bit_a(1'b1);
        start_a = 1'b0;
        for (int i = 0; i < 16; i++) bit_a(w[i]);
        chk("t6b_dout", {16'h0, dout_a}, 32'h1234);

        // 6c: din_valid while idle is ignored
        step();
        for (int i = 0; i < 4; i++) bit_a(i[0]);
        chk("t6c_dout", {16'h0, dout_a}, 32'h1234);
        chk("t6c_sel", {28'h0, sel_a}, 32'h0);
        chk("t6c_busy", {31'h0, busy_a}, 32'h0);
        step();
        chk("t6c_dvo", {31'h0, dvo_a}, 32'h0);

        step();
        chk("sb_a_drained", exp_q_a.size(), 32'h0);
        chk("sb_b_drained", exp_q_b.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
